alu_op_sequencer: RTL and testbench

//   Operator front-end for the 2-bit ALU. Collects A, B and the opcode from board

---
 rtl/alu_op_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Operator front-end for the small ALU: collects A, B and opcode over three load
// strobes, registers the ALU result/flags and holds them for display in SHOW.
// Optional build macro ALU_SEQ_CHAIN_EN: a load in SHOW chains res_q into A.
module alu_op_sequencer #(
  parameter int WIDTH          = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_data,
  input  logic             load,
  input  logic             cancel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  input  logic             alu_s,
  output logic [WIDTH-1:0] res_q,
  output logic [3:0]       flags_q,
  output logic             res_valid,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_e;

  // Counter only needs to reach TIMEOUT_CYCLES-1; a zero timeout keeps it idle.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    res_d       = res_q;
    flags_d     = flags_q;
    res_valid_d = res_valid_q;
    cnt_d       = '0;

    if (cancel) begin
      // Abort beats any load in the same cycle; result registers are kept.
      state_d     = GET_A;
      a_d         = '0;
      b_d         = '0;
      sel_d       = '0;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        GET_A: begin
          if (load) begin
            a_d     = sw_data;
            state_d = GET_B;
          end
        end
        GET_B: begin
          if (load) begin
            b_d     = sw_data;
            state_d = GET_OP;
          end
        end
        GET_OP: begin
          if (load) begin
            sel_d   = sw_data[1:0];
            state_d = EXEC;
          end
        end
        EXEC: begin
          // ALU is combinational off a_q/b_q/sel_q, so it is settled here.
          res_d       = alu_result;
          flags_d     = {alu_z, alu_c, alu_v, alu_s};
          res_valid_d = 1'b1;
          state_d     = SHOW;
        end
        SHOW: begin
          if (load) begin
            res_valid_d = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
            a_d         = res_q;
            state_d     = GET_B;
`else
            state_d     = GET_A;
`endif
          end else if (timeout_hit) begin
            res_valid_d = 1'b0;
            state_d     = GET_A;
          end else if (TIMEOUT_EN) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d     = GET_A;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      res_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      res_q       <= res_d;
      flags_q     <= flags_d;
      res_valid_q <= res_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign res_valid = res_valid_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 2-bit ALU in the loop.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] sw_data;
  logic       load, cancel;
  logic [1:0] alu_a, alu_b, alu_sel, alu_result, res_q;
  logic       alu_z, alu_c, alu_v, alu_s;
  logic [3:0] flags_q;
  logic       res_valid;
  logic [2:0] state_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(2), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw_data(sw_data), .load(load), .cancel(cancel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_s(alu_s),
    .res_q(res_q), .flags_q(flags_q), .res_valid(res_valid), .state_o(state_o)
  );

  // Stand-in ALU: SUM, SUB (A + ~B + 1), AND, OR with Z/C/V/S flags.
  logic [2:0] t;
  always_comb begin
    t     = '0;
    alu_v = 1'b0;
    case (alu_sel)
      2'd0: begin
        t     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[1] == alu_b[1]) && (t[1] != alu_a[1]);
      end
      2'd1: begin
        t     = {1'b0, alu_a} + {1'b0, ~alu_b} + 3'd1;
        alu_v = (alu_a[1] != alu_b[1]) && (t[1] != alu_a[1]);
      end
      2'd2:    t = {1'b0, alu_a & alu_b};
      default: t = {1'b0, alu_a | alu_b};
    endcase
    alu_result = t[1:0];
    alu_c      = (alu_sel[1] == 1'b0) ? t[2] : 1'b0;
    alu_z      = (t[1:0] == 2'b00);
    alu_s      = t[1];
  end

  typedef struct {
    logic [1:0] a, b, sel, res;
    logic [3:0] flg;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [1:0] v);
    sw_data = v;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  // Enter A, B, op from GET_A and stop in SHOW after checking the capture.
  task automatic run_vec(input vec_t v, input string tag);
    do_load(v.a);   chk({tag, " st_b"}, state_o, 1);
    do_load(v.b);   chk({tag, " st_op"}, state_o, 2);
    do_load(v.sel); chk({tag, " st_exec"}, state_o, 3);
    chk({tag, " vld_exec"}, res_valid, 0);
    step();
    chk({tag, " st_show"}, state_o, 4);
    chk({tag, " vld"}, res_valid, 1);
    chk({tag, " res"}, res_q, v.res);
    chk({tag, " flags"}, flags_q, v.flg);
    chk({tag, " alu_a"}, alu_a, v.a);
    chk({tag, " alu_b"}, alu_b, v.b);
    chk({tag, " alu_sel"}, alu_sel, v.sel);
  endtask

  initial begin
    vecs[0] = '{a: 2'b01, b: 2'b01, sel: 2'b00, res: 2'b10, flg: 4'b0011};
    vecs[1] = '{a: 2'b11, b: 2'b01, sel: 2'b00, res: 2'b00, flg: 4'b1100};
    vecs[2] = '{a: 2'b01, b: 2'b10, sel: 2'b01, res: 2'b11, flg: 4'b0011};
    vecs[3] = '{a: 2'b10, b: 2'b11, sel: 2'b10, res: 2'b10, flg: 4'b0001};
    vecs[4] = '{a: 2'b00, b: 2'b00, sel: 2'b11, res: 2'b00, flg: 4'b1000};
    vecs[5] = '{a: 2'b10, b: 2'b10, sel: 2'b00, res: 2'b00, flg: 4'b1110};
    vecs[6] = '{a: 2'b00, b: 2'b01, sel: 2'b01, res: 2'b11, flg: 4'b0001};
    vecs[7] = '{a: 2'b10, b: 2'b01, sel: 2'b01, res: 2'b01, flg: 4'b0110};

    rst_n = 1'b0; load = 1'b0; cancel = 1'b0; sw_data = 2'b00;
    step(); step();
    chk("rst state", state_o, 0);
    chk("rst res", res_q, 0);
    chk("rst flags", flags_q, 0);
    chk("rst valid", res_valid, 0);
    chk("rst a", alu_a, 0);
    rst_n = 1'b1;

    // Reset asserted mid-GET_B clears captured A.
    do_load(2'b11);
    chk("midb state", state_o, 1);
    chk("midb a", alu_a, 3);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    chk("midb rst state", state_o, 0);
    chk("midb rst a", alu_a, 0);
    chk("midb rst b", alu_b, 0);
    chk("midb rst sel", alu_sel, 0);
    chk("midb rst valid", res_valid, 0);

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      do_cancel();
      chk($sformatf("vec%0d cancel st", i), state_o, 0);
      chk($sformatf("vec%0d cancel vld", i), res_valid, 0);
      chk($sformatf("vec%0d cancel keep", i), res_q, vecs[i].res);
      chk($sformatf("vec%0d cancel a", i), alu_a, 0);
    end

    // Timeout: SHOW lasts exactly 4 cycles with TIMEOUT_CYCLES=4.
    run_vec(vecs[0], "to");
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("to hold%0d st", k), state_o, 4);
      chk($sformatf("to hold%0d vld", k), res_valid, 1);
    end
    step();
    chk("to exit st", state_o, 0);
    chk("to exit vld", res_valid, 0);
    chk("to keep res", res_q, 2'b10);
    chk("to keep flags", flags_q, 4'b0011);

    // Load in SHOW.
    run_vec(vecs[0], "shw");
    do_load(2'b00);
    chk("shw load vld", res_valid, 0);
`ifdef ALU_SEQ_CHAIN_EN
    chk("shw load st", state_o, 1);
    chk("shw chain a", alu_a, 2'b10);
`else
    chk("shw load st", state_o, 0);
    chk("shw keep a", alu_a, 2'b01);
`endif
    do_cancel();

    // Load during EXEC is ignored.
    do_load(2'b10); do_load(2'b11); do_load(2'b10);
    chk("exld st", state_o, 3);
    do_load(2'b01);
    chk("exld show", state_o, 4);
    chk("exld res", res_q, 2'b10);
    chk("exld flags", flags_q, 4'b0001);
    chk("exld a", alu_a, 2'b10);
    chk("exld sel", alu_sel, 2'b10);
    do_cancel();

    // cancel + load together in GET_B: cancel wins.
    do_load(2'b01);
    chk("cl st_b", state_o, 1);
    cancel = 1'b1; load = 1'b1; sw_data = 2'b11;
    step();
    cancel = 1'b0; load = 1'b0;
    chk("cl st", state_o, 0);
    chk("cl a", alu_a, 0);
    chk("cl b", alu_b, 0);

    // cancel during EXEC: no capture.
    do_load(2'b11); do_load(2'b01); do_load(2'b00);
    chk("cx st", state_o, 3);
    do_cancel();
    chk("cx st_a", state_o, 0);
    chk("cx vld", res_valid, 0);
    chk("cx res", res_q, 2'b10);
    chk("cx flags", flags_q, 4'b0001);
    chk("cx sel", alu_sel, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
